// File: rtl/wb_commit_queue.sv
// -----------------------------------------------------------------------------
// wb_commit_queue
//
// Write-back commit stage. Unpacks the MEM/WB word, picks the zero-extended
// load data or the ALU result, and holds register-file writes in a small
// in-order queue until the register-file write port accepts them. Pending
// writes can be searched for forwarding, and a full queue stalls MEM.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   synchronous active-low reset
//   mem_wb_in    in   {mem_rd, writeBack, destin, result_alu, dato}
//   in_valid     in   mem_wb_in is a live instruction this cycle
//   stall_out    out  queue full, MEM must hold its word
//   rf_we        out  head entry valid (write request)
//   rf_waddr     out  head destination (0 when empty)
//   rf_wdata     out  head data (0 when empty)
//   rf_ready     in   register file accepts the write this cycle
//   fwd_raddr    in   forwarding lookup index
//   fwd_hit      out  some pending entry targets fwd_raddr
//   fwd_data     out  data of the youngest matching entry (0 on miss)
//   queue_level  out  occupied entries
//   wb_count     out  retired-write counter, wraps at 16 bits
//
// Handshake: a write retires on a cycle where rf_we && rf_ready at the rising
// edge; rf_waddr/rf_wdata stay stable until then. rf_ready is ignored while
// rf_we is low. On the input side a word is taken when in_valid && writeBack
// && !stall_out; a word offered while stall_out is high is ignored and must be
// re-presented.
// -----------------------------------------------------------------------------
module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int LOAD_W = 12
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [2+ADDR_W+DATA_W+LOAD_W-1:0] mem_wb_in,
    input  logic                              in_valid,
    output logic                              stall_out,
    output logic                              rf_we,
    output logic [ADDR_W-1:0]                 rf_waddr,
    output logic [DATA_W-1:0]                 rf_wdata,
    input  logic                              rf_ready,
    input  logic [ADDR_W-1:0]                 fwd_raddr,
    output logic                              fwd_hit,
    output logic [DATA_W-1:0]                 fwd_data,
    output logic [$clog2(DEPTH):0]            queue_level,
    output logic [15:0]                       wb_count
);

    localparam int IN_W  = 2 + ADDR_W + DATA_W + LOAD_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Unpacked input fields
    logic              w_mem_rd;
    logic              w_wb;
    logic [ADDR_W-1:0] w_dest;
    logic [DATA_W-1:0] w_alu;
    logic [LOAD_W-1:0] w_dato;
    logic [DATA_W-1:0] w_data;

    assign w_mem_rd = mem_wb_in[IN_W-1];
    assign w_wb     = mem_wb_in[IN_W-2];
    assign w_dest   = mem_wb_in[IN_W-3 -: ADDR_W];
    assign w_alu    = mem_wb_in[LOAD_W +: DATA_W];
    assign w_dato   = mem_wb_in[LOAD_W-1:0];
    // Loads are zero-extended, never sign-extended.
    assign w_data   = w_mem_rd ? {{(DATA_W-LOAD_W){1'b0}}, w_dato} : w_alu;

    // Queue storage and bookkeeping
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [15:0]       r_wb_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    // A full queue refuses input even if the head retires this same cycle,
    // so stall_out depends on registered state only.
    assign w_push  = in_valid && w_wb && !w_full;
    assign w_pop   = !w_empty && rf_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_wb_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop) begin
                r_rptr     <= r_rptr + PTR_W'(1);
                r_wb_count <= r_wb_count + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Entry contents need no reset: they are only observed below r_level.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_wptr] <= w_dest;
            r_data[r_wptr] <= w_data;
        end
    end

    // Forwarding: walk entries oldest to youngest so the last match, the
    // youngest, is the one that sticks.
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + PTR_W'(i);
            if ((LVL_W'(i) < r_level) && (r_addr[w_idx] == fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_idx];
            end
        end
    end

    assign stall_out   = w_full;
    assign rf_we       = !w_empty;
    assign rf_waddr    = w_empty ? '0 : r_addr[r_rptr];
    assign rf_wdata    = w_empty ? '0 : r_data[r_rptr];
    assign queue_level = r_level;
    assign wb_count    = r_wb_count;

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic [33:0] mem_wb_in;
    logic        in_valid;
    logic        stall_out;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic [3:0]  fwd_raddr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [2:0]  queue_level;
    logic [15:0] wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_commit_queue #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(4), .LOAD_W(12)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_wb_in   (mem_wb_in),
        .in_valid    (in_valid),
        .stall_out   (stall_out),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_ready    (rf_ready),
        .fwd_raddr   (fwd_raddr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .queue_level (queue_level),
        .wb_count    (wb_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: a queue of pending writes plus a retire counter
    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_cnt = 16'd0;

    function automatic logic [33:0] mk(input logic rd, input logic wb, input logic [3:0] dst,
                                       input logic [15:0] alu, input logic [11:0] dato);
        return {rd, wb, dst, alu, dato};
    endfunction

    // Advance one clock and apply the commit rules to the model.
    task automatic tick();
        ent_t e;
        logic pop;
        logic push;
        @(posedge clock);
        if (!reset_n) begin
            mq.delete();
            m_cnt = 16'd0;
        end else begin
            pop  = (mq.size() != 0) && rf_ready;
            push = in_valid && mem_wb_in[32] && (mq.size() < DEPTH);
            e.a  = mem_wb_in[31:28];
            e.d  = mem_wb_in[33] ? {4'h0, mem_wb_in[11:0]} : mem_wb_in[27:12];
            if (pop) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; rf_ready = 1'b0; mem_wb_in = '0; fwd_raddr = 4'h0;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we); end
        n_checks++; if (rf_waddr !== 4'h0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0h expected 0", rf_waddr); end
        n_checks++; if (rf_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_rf_wdata: got %0h expected 0", rf_wdata); end
        n_checks++; if (queue_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", queue_level); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall_out); end
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin n_fail++; $display("FAIL reset_fwd: got %0b/%0h expected 0/0", fwd_hit, fwd_data); end
        n_checks++; if (wb_count !== 16'h0) begin n_fail++; $display("FAIL reset_wb_count: got %0h expected 0", wb_count); end
    endtask

    task automatic test_alu_write();
        in_valid = 1'b1; rf_ready = 1'b1;
        mem_wb_in = mk(1'b0, 1'b1, 4'h3, 16'hBEEF, 12'h000);
        tick();
        in_valid = 1'b0;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_rf_we: got %0b expected 1", rf_we); end
        n_checks++; if (rf_waddr !== 4'h3) begin n_fail++; $display("FAIL alu_waddr: got %0h expected 3", rf_waddr); end
        n_checks++; if (rf_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL alu_wdata: got %0h expected beef", rf_wdata); end
        tick();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_rf_we_after: got %0b expected 0", rf_we); end
        n_checks++; if (wb_count !== 16'd1) begin n_fail++; $display("FAIL alu_wb_count: got %0h expected 1", wb_count); end
    endtask

    task automatic test_load_write();
        in_valid = 1'b1; rf_ready = 1'b0;
        mem_wb_in = mk(1'b1, 1'b1, 4'h7, 16'h1234, 12'hABC);
        tick();
        in_valid = 1'b0;
        n_checks++; if (rf_waddr !== 4'h7) begin n_fail++; $display("FAIL load_waddr: got %0h expected 7", rf_waddr); end
        n_checks++; if (rf_wdata !== 16'h0ABC) begin n_fail++; $display("FAIL load_wdata: got %0h expected 0abc", rf_wdata); end
        rf_ready = 1'b1;
        tick();
        n_checks++; if (queue_level !== 3'd0) begin n_fail++; $display("FAIL load_drain_level: got %0d expected 0", queue_level); end
        in_valid = 1'b1;
        mem_wb_in = mk(1'b0, 1'b0, 4'h5, 16'h5555, 12'h000);
        tick();
        in_valid = 1'b0;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL nowb_rf_we: got %0b expected 0", rf_we); end
        n_checks++; if (queue_level !== 3'd0) begin n_fail++; $display("FAIL nowb_level: got %0d expected 0", queue_level); end
    endtask

    task automatic test_back_pressure();
        rf_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            mem_wb_in = mk(1'b0, 1'b1, 4'(k), 16'h1000 + 16'(k), 12'h000);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (queue_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d expected 4", queue_level); end
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL bp_stall: got %0b expected 1", stall_out); end
        rf_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 4'(k) || rf_wdata !== 16'h1000 + 16'(k)) begin
                n_fail++;
                $display("FAIL bp_order_%0d: got we=%0b %0h/%0h expected we=1 %0h/%0h",
                         k, rf_we, rf_waddr, rf_wdata, k, 16'h1000 + 16'(k));
            end
            tick();
            if (k == 1) begin
                n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL bp_stall_drop: got %0b expected 0", stall_out); end
            end
        end
        n_checks++; if (rf_we !== 1'b0 || queue_level !== 3'd0) begin n_fail++; $display("FAIL bp_empty: got we=%0b lvl=%0d expected 0/0", rf_we, queue_level); end
    endtask

    task automatic test_forwarding();
        rf_ready = 1'b0; in_valid = 1'b1;
        mem_wb_in = mk(1'b0, 1'b1, 4'h2, 16'h0011, 12'h000); tick();
        mem_wb_in = mk(1'b0, 1'b1, 4'h2, 16'h0022, 12'h000); tick();
        in_valid = 1'b0;
        fwd_raddr = 4'h2; #1;
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0022) begin n_fail++; $display("FAIL fwd_youngest: got %0b/%0h expected 1/0022", fwd_hit, fwd_data); end
        fwd_raddr = 4'h5; #1;
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin n_fail++; $display("FAIL fwd_miss: got %0b/%0h expected 0/0", fwd_hit, fwd_data); end
        in_valid = 1'b1;
        mem_wb_in = mk(1'b0, 1'b1, 4'h5, 16'h0055, 12'h000); #1;
        n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle: got %0b expected 0", fwd_hit); end
        tick();
        in_valid = 1'b0; #1;
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0055) begin n_fail++; $display("FAIL fwd_next_cycle: got %0b/%0h expected 1/0055", fwd_hit, fwd_data); end
        rf_ready = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (queue_level !== 3'd0) begin n_fail++; $display("FAIL fwd_drain: got %0d expected 0", queue_level); end
    endtask

    task automatic test_random();
        logic [33:0] w;
        logic        e_hit;
        logic [15:0] e_fd;
        logic [3:0]  e_a;
        logic [15:0] e_d;
        for (int i = 0; i < 400; i++) begin
            w[31:0]   = $urandom;
            w[31:28]  = 4'($urandom_range(0, 3));
            w[32]     = ($urandom_range(0, 3) != 0);
            w[33]     = 1'($urandom_range(0, 1));
            mem_wb_in = w;
            in_valid  = 1'($urandom_range(0, 1));
            rf_ready  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fwd_raddr = 4'($urandom_range(0, 4));
            #1;
            e_hit = 1'b0; e_fd = 16'h0;
            foreach (mq[k]) if (mq[k].a == fwd_raddr) begin e_hit = 1'b1; e_fd = mq[k].d; end
            e_a = (mq.size() != 0) ? mq[0].a : 4'h0;
            e_d = (mq.size() != 0) ? mq[0].d : 16'h0;
            n_checks++; if (rf_we !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_rf_we[%0d]: got %0b expected %0b", i, rf_we, mq.size() != 0); end
            n_checks++; if (rf_waddr !== e_a || rf_wdata !== e_d) begin n_fail++; $display("FAIL rnd_head[%0d]: got %0h/%0h expected %0h/%0h", i, rf_waddr, rf_wdata, e_a, e_d); end
            n_checks++; if (queue_level !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, queue_level, mq.size()); end
            n_checks++; if (stall_out !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", i, stall_out, mq.size() == DEPTH); end
            n_checks++; if (fwd_hit !== e_hit || fwd_data !== e_fd) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %0b/%0h expected %0b/%0h", i, fwd_hit, fwd_data, e_hit, e_fd); end
            n_checks++; if (wb_count !== m_cnt) begin n_fail++; $display("FAIL rnd_wb_count[%0d]: got %0h expected %0h", i, wb_count, m_cnt); end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rf_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_wb_in = mk(1'b0, 1'b1, 4'(k + 8), 16'hA000 + 16'(k), 12'h000);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (queue_level !== 3'(mq.size())) begin n_fail++; $display("FAIL rm_prefill: got %0d expected %0d", queue_level, mq.size()); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_checks++; if (queue_level !== 3'd0) begin n_fail++; $display("FAIL rm_level: got %0d expected 0", queue_level); end
        n_checks++; if (wb_count !== 16'd0) begin n_fail++; $display("FAIL rm_wb_count: got %0h expected 0", wb_count); end
        rf_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rm_stale_%0d: got %0b expected 0", k, rf_we); end
            tick();
        end
        n_checks++; if (wb_count !== 16'd0) begin n_fail++; $display("FAIL rm_count_after: got %0h expected 0", wb_count); end
    endtask

    task automatic test_counter_wrap();
        in_valid = 1'b1; rf_ready = 1'b1;
        mem_wb_in = mk(1'b0, 1'b1, 4'h1, 16'h0001, 12'h000);
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) tick();
        n_checks++; if (wb_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %0h expected ffff", wb_count); end
        tick();
        n_checks++; if (wb_count !== 16'h0000) begin n_fail++; $display("FAIL wrap: got %0h expected 0000", wb_count); end
        in_valid = 1'b0;
        tick(); tick(); tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_write();
        test_back_pressure();
        test_forwarding();
        test_random();
        test_reset_mid();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Write-back commit stage that consumes the 34-bit packed MEM/WB word and retires register-file writes through a small in-order queue. It unpacks the word, selects load data or the ALU result, and buffers writes until the register-file write port accepts them. It provides a forwarding lookup over pending writes and back-pressure to the MEM stage. It sits between the MEM/WB pipeline register and the vector register-file write port.

## Interface
- DEPTH, 4, queue entries (power of 2, ≥2)
- DATA_W, 16, register-file data width
- ADDR_W, 4, register index width
- LOAD_W, 12, load-data field width
- clock  in  1  system clock, rising-edge sampled
- reset_n  in  1  synchronous, active-low reset
- mem_wb_in  in  34  packed word: [33] mem_rd, [32] writeBack, [31:28] destin, [27:12] result_alu, [11:0] dato
- in_valid  in  1  mem_wb_in carries a live instruction this cycle
- stall_out  out  1  queue full; MEM stage must hold its word
- rf_we  out  1  head entry valid, write request
- rf_waddr  out  ADDR_W  head destination
- rf_wdata  out  DATA_W  head data
- rf_ready  in  1  register file accepts write this cycle
- fwd_raddr  in  ADDR_W  forwarding lookup index
- fwd_hit  out  1  a pending entry targets fwd_raddr
- fwd_data  out  DATA_W  data of youngest matching pending entry
- queue_level  out  $clog2(DEPTH)+1  occupied entries
- wb_count  out  16  retired write counter

## Operation
- Unpack: data = mem_rd ? {(DATA_W-LOAD_W)'b0, dato} : result_alu (zero-extend loads, no sign extension).
- Enqueue when in_valid && writeBack && !full; entry = {destin, data}. writeBack=0 words are dropped, not counted, no stall effect.
- Register 0 is an ordinary destination (no hardwired zero).
- Full (level==DEPTH): stall_out=1, input ignored even if a dequeue occurs the same cycle; upstream re-presents the word.
- Dequeue: rf_we = (level!=0); rf_waddr/rf_wdata = head entry, held stable until rf_we && rf_ready; pop on that handshake.
- Simultaneous enqueue and pop when not full: both occur, level unchanged.
- Empty: rf_we=0, rf_waddr=0, rf_wdata=0.
- Forwarding: combinational search of all valid entries including the head; youngest match wins; no match → fwd_hit=0, fwd_data=0. Input being enqueued this cycle is not visible until next cycle.
- wb_count increments by 1 per rf handshake; wraps 0xFFFF→0x0000.
- Read/write pointers wrap modulo DEPTH; strict FIFO order.

## Timing
- MEM/WB word updates on the falling edge; this block samples on the rising edge (half-cycle setup).
- Latency: word accepted at edge N → rf_we=1 with that entry after edge N (visible cycle N+1), given empty queue.
- Throughput: one enqueue and one retire per cycle.
- stall_out, queue_level, rf_* derived from registered state only (no combinational path from in_valid).
- Reset (reset_n=0 at rising edge): pointers 0, level 0, stall_out 0, rf_we 0, rf_waddr 0, rf_wdata 0, fwd_hit 0, fwd_data 0, wb_count 0. Reset mid-operation discards all pending writes; no write issued in the reset cycle's following cycle.
- rf_ready ignored while rf_we=0.

## Test plan
- ALU write: in_valid=1, word {0,1,4'h3,16'hBEEF,12'h000}, rf_ready=1 → next cycle rf_we=1, rf_waddr=3, rf_wdata=BEEF; following cycle rf_we=0, wb_count=1.
- Load write: {1,1,4'h7,16'h1234,12'hABC} → rf_wdata=0x0ABC, rf_waddr=7; writeBack=0 word → no rf_we, level stays 0.
- Back-pressure: rf_ready=0, enqueue 5 valid writes back-to-back → level=4, stall_out=1, 5th not stored; raise rf_ready → writes retire in order 1..4, stall_out drops after first pop.
- Forwarding: queue holds dest 2=0x0011 then dest 2=0x0022, rf_ready=0, fwd_raddr=2 → fwd_hit=1, fwd_data=0x0022; fwd_raddr=5 → fwd_hit=0, fwd_data=0.
- Reset mid-operation: 3 pending entries, reset_n=0 one cycle → level=0, rf_we=0, wb_count=0, no stale writes afterward.
- Counter wrap: preload by 65535 retirements (or force) then one more → wb_count=0x0000.
